// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- execute-stage hazard and forwarding controller.
//
// Tracks the destination registers of the instructions in the EX and MEM
// slots, produces registered forwarding selects for the execute-stage
// operand muxes, and stalls decode on hazards that forwarding cannot cover.
//
// Build option:
//   HAZARD_FWD_EN defined   : EX->MEM / MEM->WB forwarding. Only a load-use
//                             pair stalls, and it stalls for one cycle.
//   HAZARD_FWD_EN undefined : no forwarding. fwd selects are tied to 0 and any
//                             RAW dependency on the EX or MEM slot stalls.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   decode holds a valid instruction
//   id_rs1/id_rs2              source register indices
//   id_use_rs1/id_use_rs2      instruction actually reads that source
//   id_rd/id_reg_write         destination index and write enable
//   id_is_load                 instruction is a load
//   flush                      kill the decode instruction (branch taken in EX)
//   mem_busy                   freeze all tracked state
//   issue  (comb)              decode instruction enters EX this cycle
//   stall  (comb)              hold PC and IF/ID
//   ex_valid (reg)             EX slot holds a real instruction
//   fwd_a_sel/fwd_b_sel (reg)  0 = register file, 1 = MEM result, 2 = WB result
//   stall_count (reg)          saturating count of stall cycles
//
// The WB slot is not stored: the register file is write-before-read, so an
// instruction in WB never needs a forward or a stall and its fields would be
// dead state.

module ex_hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_reg_write,
    input  logic                id_is_load,
    input  logic                flush,
    input  logic                mem_busy,
    output logic                issue,
    output logic                stall,
    output logic                ex_valid,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic [CNT_BITS-1:0] stall_count
);

    // ------------------------------------------------------------------
    // Tracked slots
    // ------------------------------------------------------------------
    logic                ex_v_q,   ex_v_d;
    logic [REG_BITS-1:0] ex_rd_q,  ex_rd_d;
    logic                ex_rw_q,  ex_rw_d;
    logic                ex_ld_q,  ex_ld_d;

    // MEM slot never needs is_load: a load in MEM is forwarded from WB.
    logic                mem_v_q,  mem_v_d;
    logic [REG_BITS-1:0] mem_rd_q, mem_rd_d;
    logic                mem_rw_q, mem_rw_d;

    logic [1:0]          fwd_a_q,  fwd_a_d;
    logic [1:0]          fwd_b_q,  fwd_b_d;
    logic [CNT_BITS-1:0] cnt_q,    cnt_d;

    // ------------------------------------------------------------------
    // Hazard detection against EX and MEM
    // ------------------------------------------------------------------
    logic ex_wr, mem_wr;
    logic haz_ex_a, haz_ex_b, haz_mem_a, haz_mem_b;
    logic hazard;

    always_comb begin
        // A slot is a live producer only if it writes a non-zero register.
        ex_wr     = ex_v_q  & ex_rw_q  & (ex_rd_q  != '0);
        mem_wr    = mem_v_q & mem_rw_q & (mem_rd_q != '0);
        haz_ex_a  = ex_wr  & id_use_rs1 & (ex_rd_q  == id_rs1);
        haz_ex_b  = ex_wr  & id_use_rs2 & (ex_rd_q  == id_rs2);
        haz_mem_a = mem_wr & id_use_rs1 & (mem_rd_q == id_rs1);
        haz_mem_b = mem_wr & id_use_rs2 & (mem_rd_q == id_rs2);
`ifdef HAZARD_FWD_EN
        // Only a load in EX cannot be covered: its data exists after MEM.
        hazard    = ex_ld_q & (haz_ex_a | haz_ex_b);
`else
        hazard    = haz_ex_a | haz_ex_b | haz_mem_a | haz_mem_b;
`endif
    end

    // flush beats stall: a flushed instruction is dropped, never held.
    assign stall = id_valid & hazard & ~flush & ~reset;
    assign issue = id_valid & ~stall & ~flush & ~mem_busy & ~reset;

    // ------------------------------------------------------------------
    // Forward select for the instruction being issued
    // ------------------------------------------------------------------
    logic [1:0] sel_a, sel_b;

    always_comb begin
        sel_a = 2'd0;
        sel_b = 2'd0;
`ifdef HAZARD_FWD_EN
        // EX is checked first: the newest producer of a register wins.
        if (haz_ex_a)       sel_a = 2'd1;
        else if (haz_mem_a) sel_a = 2'd2;
        if (haz_ex_b)       sel_b = 2'd1;
        else if (haz_mem_b) sel_b = 2'd2;
`endif
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        // mem_busy freezes everything: default is hold.
        ex_v_d   = ex_v_q;
        ex_rd_d  = ex_rd_q;
        ex_rw_d  = ex_rw_q;
        ex_ld_d  = ex_ld_q;
        mem_v_d  = mem_v_q;
        mem_rd_d = mem_rd_q;
        mem_rw_d = mem_rw_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        cnt_d    = cnt_q;

        if (!mem_busy) begin
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            mem_rw_d = ex_rw_q;

            // A non-issued cycle inserts a bubble with clean selects.
            ex_v_d   = issue;
            ex_rd_d  = issue ? id_rd        : '0;
            ex_rw_d  = issue & id_reg_write;
            ex_ld_d  = issue & id_is_load;
            fwd_a_d  = issue ? sel_a : 2'd0;
            fwd_b_d  = issue ? sel_b : 2'd0;

            if (stall && !(&cnt_q))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            fwd_a_q  <= 2'd0;
            fwd_b_q  <= 2'd0;
            cnt_q    <= '0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_rw_q  <= ex_rw_d;
            ex_ld_q  <= ex_ld_d;
            mem_v_q  <= mem_v_d;
            mem_rd_q <= mem_rd_d;
            mem_rw_q <= mem_rw_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            cnt_q    <= cnt_d;
        end
    end

    // The EX slot valid bit is exactly the registered ex_valid output.
    assign ex_valid    = ex_v_q;
    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int RB = 5;
    localparam int CB = 4;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [RB-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic          id_reg_write = 1'b0, id_is_load = 1'b0;
    logic          flush = 1'b0, mem_busy = 1'b0;
    logic          issue, stall, ex_valid;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CB-1:0] stall_count;

    ex_hazard_ctrl #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .mem_busy(mem_busy),
        .issue(issue), .stall(stall), .ex_valid(ex_valid),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: the two most recent instructions to enter EX,
    // newest first (index 0 = EX, index 1 = MEM).
    typedef struct { bit v; int rd; bit rw; bit ld; } instr_t;
    instr_t pipe [2];
    int m_exv, m_fa, m_fb, m_cnt;
    bit e_stall, e_issue, d_stall, d_issue;

    // Distance to the nearest in-flight producer of rs (1 = EX, 2 = MEM, 0 = none).
    function automatic int pdist(int rs, bit use_it);
        for (int k = 0; k < 2; k++)
            if (use_it && pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs)
                return k + 1;
        return 0;
    endfunction

    // One clock: sample combinational outputs mid-cycle, advance model and DUT.
    task automatic cyc();
        int da, db;
        bit hz;
        #2;
        da = pdist(int'(id_rs1), id_use_rs1);
        db = pdist(int'(id_rs2), id_use_rs2);
`ifdef HAZARD_FWD_EN
        hz = ((da == 1) || (db == 1)) && pipe[0].ld;
`else
        hz = (da != 0) || (db != 0);
`endif
        e_stall = id_valid && hz && !flush && !reset;
        e_issue = id_valid && !e_stall && !flush && !mem_busy && !reset;
        d_stall = stall;
        d_issue = issue;
        @(posedge clk);
        if (reset) begin
            pipe[0] = '{0, 0, 0, 0};
            pipe[1] = '{0, 0, 0, 0};
            m_exv = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        end else if (!mem_busy) begin
            pipe[1] = pipe[0];
            pipe[0] = e_issue ? '{1'b1, int'(id_rd), id_reg_write, id_is_load} : '{0, 0, 0, 0};
            m_exv = e_issue ? 1 : 0;
`ifdef HAZARD_FWD_EN
            m_fa = e_issue ? da : 0;
            m_fb = e_issue ? db : 0;
`else
            m_fa = 0;
            m_fb = 0;
`endif
            if (e_stall && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic drv(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit ld);
        id_valid = v; id_rs1 = RB'(rs1); id_use_rs1 = u1; id_rs2 = RB'(rs2); id_use_rs2 = u2;
        id_rd = RB'(rd); id_reg_write = rw; id_is_load = ld;
        flush = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv(1, 1, 1, 1, 1, 1, 1, 1);
        cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (d_issue !== 1'b0) $display("FAIL rst_issue got %0b want 0", d_issue); else n_pass++;
        n_tot++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid got %0b want 0", ex_valid); else n_pass++;
        n_tot++; if ({fwd_a_sel, fwd_b_sel} !== 4'd0) $display("FAIL rst_fwd got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); else n_pass++;
        n_tot++; if (stall_count !== '0) $display("FAIL rst_count got %0d want 0", stall_count); else n_pass++;
        reset = 1'b0;
    endtask

    // A hazard stall interrupted by reset: all tracking and the counter clear.
    task automatic test_reset_mid_stall();
        do_reset();
        drv(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        drv(1, 5, 1, 0, 0, 6, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b1) $display("FAIL rms_stall got %0b want 1", d_stall); else n_pass++;
        reset = 1'b1; cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL rms_stall_in_reset got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (stall_count !== '0) $display("FAIL rms_count got %0d want 0", stall_count); else n_pass++;
        reset = 1'b0; cyc();
        n_tot++; if (d_issue !== 1'b1) $display("FAIL rms_issue_after got %0b want 1", d_issue); else n_pass++;
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_fwd_ex();
        do_reset();
        drv(1, 0, 0, 0, 0, 3, 1, 0); cyc();
        drv(1, 3, 1, 4, 1, 9, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL fwd_ex_stall got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (ex_valid !== 1'b1) $display("FAIL fwd_ex_valid got %0b want 1", ex_valid); else n_pass++;
        n_tot++; if (fwd_a_sel !== 2'd1) $display("FAIL fwd_ex_a got %0d want 1", fwd_a_sel); else n_pass++;
        n_tot++; if (fwd_b_sel !== 2'd0) $display("FAIL fwd_ex_b got %0d want 0", fwd_b_sel); else n_pass++;
    endtask

    task automatic test_fwd_mem();
        do_reset();
        drv(1, 0, 0, 0, 0, 3, 1, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        drv(1, 1, 1, 3, 1, 9, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL fwd_mem_stall got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (fwd_b_sel !== 2'd2) $display("FAIL fwd_mem_b got %0d want 2", fwd_b_sel); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drv(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        drv(1, 5, 1, 0, 0, 6, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b1) $display("FAIL lu_stall got %0b want 1", d_stall); else n_pass++;
        n_tot++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got %0b want 0", ex_valid); else n_pass++;
        cyc();
        n_tot++; if (d_issue !== 1'b1) $display("FAIL lu_issue got %0b want 1", d_issue); else n_pass++;
        n_tot++; if (fwd_a_sel !== 2'd2) $display("FAIL lu_fwd_a got %0d want 2", fwd_a_sel); else n_pass++;
        n_tot++; if (stall_count !== 4'd1) $display("FAIL lu_count got %0d want 1", stall_count); else n_pass++;
    endtask

    task automatic test_x0_newest();
        do_reset();
        drv(1, 0, 0, 0, 0, 0, 1, 0); cyc();
        drv(1, 0, 1, 0, 0, 8, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL x0_stall got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (fwd_a_sel !== 2'd0) $display("FAIL x0_fwd got %0d want 0", fwd_a_sel); else n_pass++;
        drv(1, 0, 0, 0, 0, 7, 1, 0); cyc(); cyc();
        drv(1, 7, 1, 0, 0, 9, 1, 0); cyc();
        n_tot++; if (fwd_a_sel !== 2'd1) $display("FAIL newest_fwd got %0d want 1", fwd_a_sel); else n_pass++;
    endtask

    task automatic test_flush_busy();
        do_reset();
        drv(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        drv(1, 5, 1, 0, 0, 6, 1, 0); flush = 1'b1; cyc();
        n_tot++; if (d_stall !== 1'b0) $display("FAIL flush_stall got %0b want 0", d_stall); else n_pass++;
        n_tot++; if (d_issue !== 1'b0) $display("FAIL flush_issue got %0b want 0", d_issue); else n_pass++;
        n_tot++; if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid got %0b want 0", ex_valid); else n_pass++;
        // Load-use again to leave a non-zero select and count, then freeze.
        drv(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        drv(1, 5, 1, 0, 0, 6, 1, 0); cyc(); cyc();
        drv(1, 0, 0, 6, 1, 10, 1, 0); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tot++; if (d_issue !== 1'b0) $display("FAIL busy_issue[%0d] got %0b want 0", i, d_issue); else n_pass++;
            n_tot++; if ({ex_valid, fwd_a_sel, stall_count} !== {1'b1, 2'd2, 4'd1})
                $display("FAIL busy_hold[%0d] got v=%0b a=%0d c=%0d want v=1 a=2 c=1", i, ex_valid, fwd_a_sel, stall_count);
            else n_pass++;
        end
        mem_busy = 1'b0; cyc();
        // The add (rd=6) was held in EX, so the consumer forwards from MEM.
        n_tot++; if (d_issue !== 1'b1) $display("FAIL unbusy_issue got %0b want 1", d_issue); else n_pass++;
        n_tot++; if (fwd_b_sel !== 2'd1) $display("FAIL unbusy_fwd_b got %0d want 1", fwd_b_sel); else n_pass++;
    endtask
`else
    task automatic test_nofwd_stall();
        do_reset();
        drv(1, 0, 0, 0, 0, 3, 1, 0); cyc();
        drv(1, 3, 1, 0, 0, 9, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_tot++; if (d_stall !== 1'b1) $display("FAIL nf_stall[%0d] got %0b want 1", i, d_stall); else n_pass++;
            n_tot++; if (ex_valid !== 1'b0) $display("FAIL nf_bubble[%0d] got %0b want 0", i, ex_valid); else n_pass++;
        end
        cyc();
        n_tot++; if (d_issue !== 1'b1) $display("FAIL nf_issue got %0b want 1", d_issue); else n_pass++;
        n_tot++; if ({fwd_a_sel, fwd_b_sel} !== 4'd0) $display("FAIL nf_fwd got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); else n_pass++;
        n_tot++; if (stall_count !== 4'd2) $display("FAIL nf_count got %0d want 2", stall_count); else n_pass++;
        // Distance 2: one stall.
        drv(1, 0, 0, 0, 0, 4, 1, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        drv(1, 0, 0, 4, 1, 9, 1, 0); cyc();
        n_tot++; if (d_stall !== 1'b1) $display("FAIL nf_d2_stall got %0b want 1", d_stall); else n_pass++;
        cyc();
        n_tot++; if (d_issue !== 1'b1) $display("FAIL nf_d2_issue got %0b want 1", d_issue); else n_pass++;
        n_tot++; if (stall_count !== 4'd3) $display("FAIL nf_d2_count got %0d want 3", stall_count); else n_pass++;
    endtask
`endif

    // Repeated load-use pairs push the counter into saturation.
    task automatic test_saturate();
        int k;
        do_reset();
        for (int p = 0; p < 20; p++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 1);
            k = 0; do begin cyc(); k++; end while (!d_issue && k < 4);
            drv(1, 5, 1, 0, 0, 6, 1, 0);
            k = 0; do begin cyc(); k++; end while (!d_issue && k < 4);
            n_tot++; if (d_issue !== 1'b1) $display("FAIL sat_issue_timeout pair %0d got %0b want 1", p, d_issue); else n_pass++;
        end
        n_tot++; if (int'(stall_count) !== CMAX) $display("FAIL sat_count got %0d want %0d", stall_count, CMAX); else n_pass++;
        n_tot++; if (int'(stall_count) !== m_cnt) $display("FAIL sat_model got %0d want %0d", stall_count, m_cnt); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            mem_busy = ($urandom_range(0, 6) == 0);
            reset    = ($urandom_range(0, 49) == 0);
            cyc();
            n_tot++; if (d_stall !== e_stall) $display("FAIL rnd_stall @%0d got %0b want %0b", i, d_stall, e_stall); else n_pass++;
            n_tot++; if (d_issue !== e_issue) $display("FAIL rnd_issue @%0d got %0b want %0b", i, d_issue, e_issue); else n_pass++;
            n_tot++; if (int'(ex_valid) !== m_exv) $display("FAIL rnd_ex_valid @%0d got %0b want %0d", i, ex_valid, m_exv); else n_pass++;
            n_tot++; if (int'(fwd_a_sel) !== m_fa) $display("FAIL rnd_fwd_a @%0d got %0d want %0d", i, fwd_a_sel, m_fa); else n_pass++;
            n_tot++; if (int'(fwd_b_sel) !== m_fb) $display("FAIL rnd_fwd_b @%0d got %0d want %0d", i, fwd_b_sel, m_fb); else n_pass++;
            n_tot++; if (int'(stall_count) !== m_cnt) $display("FAIL rnd_count @%0d got %0d want %0d", i, stall_count, m_cnt); else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        pipe[0] = '{0, 0, 0, 0};
        pipe[1] = '{0, 0, 0, 0};
        m_exv = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        test_reset();
        test_reset_mid_stall();
`ifdef HAZARD_FWD_EN
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_x0_newest();
        test_flush_busy();
`else
        test_nofwd_stall();
`endif
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the execute stage.
- Tracks the destination registers of instructions in the EX, MEM and WB slots, issues the forwarding selects for the execute-stage operand A/B muxes, and stalls or bubbles the pipeline on load-use hazards.
- Sits between decode and execute. Consumes decoded register fields; drives execute-stage operand selection and front-end stall/bubble.

Parameters:
- REG_BITS, 5, register index width.
- CNT_BITS, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  decode holds a valid instruction
- id_rs1  input  REG_BITS  source register A index
- id_rs2  input  REG_BITS  source register B index
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_BITS  destination register index
- id_reg_write  input  1  instruction writes rd
- id_is_load  input  1  instruction is a load
- flush  input  1  taken branch/jump resolved in EX; kill the decode instruction
- mem_busy  input  1  memory stage not ready; freeze all tracked slots
- issue  output  1  combinational; decode instruction moves to EX this cycle
- stall  output  1  combinational; hold PC and IF/ID register
- ex_valid  output  1  registered; EX slot holds a real instruction
- fwd_a_sel  output  2  registered; 0 = reg A, 1 = MEM result, 2 = WB result
- fwd_b_sel  output  2  registered; same encoding for operand B
- stall_count  output  CNT_BITS  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset state:
  - EX/MEM/WB slot valid bits = 0.
  - ex_valid = 0, fwd_a_sel = fwd_b_sel = 0, stall_count = 0.
  - stall = 0 and issue = 0 while reset is high.
- Slot contents: each slot stores {valid, rd, reg_write, is_load}.
- Hazard match: slot S hazards source rsN when all of the following hold:
  - S.valid and S.reg_write are set.
  - S.rd != 0.
  - S.rd == id_rsN and id_use_rsN is set.
- Load-use hazard: EX slot is a load and hazards rs1 or rs2.
- stall = id_valid & load_use & !flush & !reset.
- issue = id_valid & !stall & !flush & !mem_busy.
- mem_busy high (not in reset):
  - All slots, ex_valid, fwd selects and stall_count hold their values.
  - stall and issue are still computed, but nothing advances.
- mem_busy low, per clock edge:
  - WB <= MEM, MEM <= EX.
  - EX <= decode fields if issue; otherwise EX.valid <= 0 (bubble).
  - ex_valid <= issue.
- Forward select for each operand, registered on issue:
  - 1 if the current EX slot hazards the source. It is in MEM next cycle; the newest producer wins.
  - Else 2 if the current MEM slot hazards the source.
  - Else 0.
- When the EX slot is a bubble, the fwd selects reset to 0.
- Latency:
  - Forward selects are valid in the same cycle ex_valid is high, one cycle after issue.
  - A load-use hazard costs exactly 1 stall cycle. The next cycle the load is in MEM and its data is forwarded from WB (sel 2).
- Register x0 is never forwarded and never causes a stall.
- The register file is write-before-read, so a WB-slot producer needs no forward.
- Simultaneous events:
  - flush wins over stall: the decode instruction is dropped and a bubble enters EX.
  - reset wins over everything.
- Reset mid-stall: all slots invalidated, stall_count cleared.
- stall_count: +1 on each clock edge with stall=1 and mem_busy=0. Saturates at all-ones, no wrap.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - stall is asserted for any hazard against the EX or MEM slot, not only load-use.
  - A dependent instruction directly behind its producer stalls 2 cycles; at distance 2 it stalls 1 cycle.
  - stall_count counts these cycles.

Test Plan:
- Reset, then add x3 (rd=3) followed by sub reading rs1=3 -> no stall; fwd_a_sel=1 with ex_valid=1 for the sub; fwd_b_sel=0.
- add x3, nop, then or reading rs2=3 -> fwd_b_sel=2, no stall.
- lw x5, then add reading rs1=5 -> stall=1 for 1 cycle, bubble (ex_valid=0), then add issues with fwd_a_sel=2; stall_count=1.
- Producer rd=0 with consumer rs1=0 -> fwd_a_sel=0, no stall. Both producers write x7 in consecutive cycles -> consumer gets sel 1 (newest).
- lw x5 + dependent add with flush=1 in the stall cycle -> stall=0, add dropped, ex_valid=0 next cycle. mem_busy=1 for 3 cycles -> slots, selects and stall_count unchanged.
- HAZARD_FWD_EN undefined: add x3 then sub reading x3 -> 2 stall cycles, selects 0, stall_count=2.
